// File: rtl/exp_mu_collector_pkg.sv
// Shared definitions for the exp-mu collector: default widths and the state encoding.
package exp_mu_collector_pkg;

  localparam int DEF_DATA_W = 17;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_SUM_W  = DEF_DATA_W + DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

endpackage

// File: rtl/exp_mu_collector_table_ram.sv
// Single-write-port table with a registered read port; no reset so it maps onto block RAM.
module table_ram #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/exp_mu_collector.sv
// Collects one table of exp-mu samples (first write per address wins), tracks sum/max,
// then streams the table out in address order under downstream iReady.
module exp_mu_collector
  import exp_mu_collector_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SUM_W  = DATA_W + ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] iData,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic              iValid,
  input  logic              iDone,
  input  logic              iDrain,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oValid,
  output logic [SUM_W-1:0]  oSum,
  output logic [DATA_W-1:0] oMax,
  output logic              oSumValid,
  output logic              oDone,
  output logic              oError,
  output logic              oBusy
);

  localparam int DEPTH = 2**ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [SUM_W-1:0]  sum_q;
  logic [DATA_W-1:0] max_q;
  logic [DEPTH-1:0]  written_q, written_d;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q, rd_ok_q, sumvld_q, done_q, err_q, last_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              acc_idle, acc_col, wr_en, beat;

  assign acc_idle = (state_q == ST_IDLE) && iValid;
  assign acc_col  = (state_q == ST_COLLECT) && iValid && !written_q[iAddr];
  assign wr_en    = acc_idle || acc_col;
  // last_q marks the cycle beat 63 is on the bus; no further reads are issued then
  assign beat     = (state_q == ST_DRAIN) && iReady && !last_q;

  always_comb begin
    written_d = written_q;
    if (acc_idle) begin
      written_d        = '0;
      written_d[iAddr] = 1'b1;
    end else if (acc_col) begin
      written_d[iAddr] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      written_q <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      rd_ok_q   <= 1'b0;
      sumvld_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      valid_q   <= beat;
      rd_ok_q   <= beat && written_q[ptr_q];
      done_q    <= 1'b0;
      written_q <= written_d;
      if (beat) begin
        addr_q <= ptr_q;
        ptr_q  <= ptr_q + ADDR_W'(1);
      end
      if (wr_en) begin
        sum_q <= (acc_idle ? '0 : sum_q) + SUM_W'(iData);
        max_q <= (acc_idle || iData > max_q) ? iData : max_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (iValid) begin
            err_q   <= 1'b0;
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (iValid && written_q[iAddr]) err_q <= 1'b1;
          if (iDone) begin
            state_q  <= ST_READY;
            sumvld_q <= 1'b1;
            if (!(&written_d)) err_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (iValid) err_q <= 1'b1;
          if (iDrain) begin
            state_q <= ST_DRAIN;
            ptr_q   <= '0;
            last_q  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (iValid) err_q <= 1'b1;
          if (beat && (&ptr_q)) last_q <= 1'b1;
          if (last_q) begin
            state_q  <= ST_IDLE;
            sumvld_q <= 1'b0;
            done_q   <= 1'b1;
            last_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  table_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_table_ram (
    .clk_i  (CLK),
    .we_i   (wr_en),
    .waddr_i(iAddr),
    .wdata_i(iData),
    .re_i   (beat),
    .raddr_i(ptr_q),
    .rdata_o(ram_rdata)
  );

  // Unwritten entries read back as zero; the RAM itself is never cleared
  assign oData     = rd_ok_q ? ram_rdata : '0;
  assign oAddr     = addr_q;
  assign oValid    = valid_q;
  assign oSum      = sum_q;
  assign oMax      = max_q;
  assign oSumValid = sumvld_q;
  assign oDone     = done_q;
  assign oError    = err_q;
  assign oBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exp_mu_collector.sv
// Frame-table bench for exp_mu_collector: drives collect frames, scoreboards drained beats.
module tb_exp_mu_collector;

  logic        CLK = 1'b0;
  logic        RST;
  logic [16:0] iData;
  logic [5:0]  iAddr;
  logic        iValid, iDone, iDrain, iReady;
  logic [16:0] oData;
  logic [5:0]  oAddr;
  logic        oValid;
  logic [22:0] oSum;
  logic [16:0] oMax;
  logic        oSumValid, oDone, oError, oBusy;

  exp_mu_collector dut (
    .CLK(CLK), .RST(RST), .iData(iData), .iAddr(iAddr), .iValid(iValid),
    .iDone(iDone), .iDrain(iDrain), .iReady(iReady), .oData(oData), .oAddr(oAddr),
    .oValid(oValid), .oSum(oSum), .oMax(oMax), .oSumValid(oSumValid), .oDone(oDone),
    .oError(oError), .oBusy(oBusy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int skip;     // address never sent, -1 for none
    int dup;      // address re-sent with value 9 after first value 7, -1 for none
    int stray;    // send an iValid while in READY
    int rev;      // data = 64 - addr instead of data = addr
    int toggle;   // iReady alternates during drain
    int rst_at;   // assert RST when this drain address is on the bus, -1 for none
    int exp_sum;
    int exp_max;
    int exp_err;
  } frame_t;

  typedef struct {
    logic [5:0]  addr;
    logic [16:0] data;
  } beat_t;

  frame_t      frames [7];
  beat_t       sb [$];
  logic [16:0] mdl [64];
  logic        mw  [64];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int a, input logic [16:0] d, input logic last);
    iValid = 1'b1;
    iAddr  = 6'(a);
    iData  = d;
    iDone  = last;
    if (!mw[a]) begin
      mdl[a] = d;
      mw[a]  = 1'b1;
    end
    step();
    iValid = 1'b0;
    iDone  = 1'b0;
  endtask

  task automatic run_drain(input int toggle, input int rst_at);
    int    beats, cyc, first_cyc, stray_cnt;
    bit    done_seen;
    beat_t b;
    for (int i = 0; i < 64; i++) begin
      b.addr = 6'(i);
      b.data = mw[i] ? mdl[i] : 17'd0;
      sb.push_back(b);
    end
    iDrain = 1'b1;
    step();
    iDrain = 1'b0;
    beats = 0; cyc = 1; first_cyc = -1; done_seen = 0;
    while (!done_seen && cyc < 400) begin
      iReady = toggle ? (cyc % 2 == 0) : 1'b1;
      step();
      cyc++;
      if (oValid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (sb.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          b = sb.pop_front();
          chk("beat_addr", oAddr, b.addr);
          chk("beat_data", oData, b.data);
        end
        beats++;
        if (rst_at >= 0 && oAddr == 6'(rst_at)) begin
          RST = 1'b1;
          step();
          RST = 1'b0;
          chk("rst_oValid", oValid, 0);
          chk("rst_oData", oData, 0);
          chk("rst_oAddr", oAddr, 0);
          chk("rst_oSum", oSum, 0);
          chk("rst_oMax", oMax, 0);
          chk("rst_flags", {oSumValid, oDone, oError, oBusy}, 0);
          stray_cnt = 0;
          for (int i = 0; i < 80; i++) begin
            step();
            if (oValid || oDone) stray_cnt++;
          end
          chk("post_rst_activity", stray_cnt, 0);
          sb.delete();
          iReady = 1'b0;
          return;
        end
      end
      if (oDone) begin
        done_seen = 1;
        chk("done_oValid", oValid, 0);
        chk("done_oBusy", oBusy, 0);
        chk("done_oSumValid", oSumValid, 0);
      end
    end
    iReady = 1'b0;
    chk("drain_done_seen", done_seen, 1);
    chk("drain_beats", beats, 64);
    chk("drain_sb_left", sb.size(), 0);
    if (!toggle) chk("first_beat_latency", first_cyc, 2);
    step();
    chk("done_one_cycle", oDone, 0);
    sb.delete();
  endtask

  task automatic run_frame(input frame_t f);
    logic [16:0] d;
    for (int i = 0; i < 64; i++) begin
      mdl[i] = 17'd0;
      mw[i]  = 1'b0;
    end
    for (int a = 0; a < 64; a++) begin
      if (a == f.skip) continue;
      d = f.rev ? 17'(64 - a) : 17'(a);
      if (a == f.dup) d = 17'd7;
      send(a, d, a == 63);
      if (a == f.dup) send(a, 17'd9, 1'b0);
    end
    chk("ready_sumvalid", oSumValid, 1);
    chk("ready_sum", oSum, f.exp_sum);
    chk("ready_max", oMax, f.exp_max);
    chk("ready_busy", oBusy, 1);
    if (f.stray != 0) begin
      send(0, 17'h1ffff, 1'b0);
      chk("stray_sum_unchanged", oSum, f.exp_sum);
    end
    chk("ready_error", oError, f.exp_err);
    run_drain(f.toggle, f.rst_at);
  endtask

  initial begin
    frames[0] = '{skip: -1, dup: -1, stray: 0, rev: 0, toggle: 0, rst_at: -1, exp_sum: 2016, exp_max: 63, exp_err: 0};
    frames[1] = '{skip: -1, dup: -1, stray: 0, rev: 0, toggle: 1, rst_at: -1, exp_sum: 2016, exp_max: 63, exp_err: 0};
    frames[2] = '{skip: -1, dup: 5,  stray: 0, rev: 0, toggle: 0, rst_at: -1, exp_sum: 2018, exp_max: 63, exp_err: 1};
    frames[3] = '{skip: 10, dup: -1, stray: 0, rev: 0, toggle: 1, rst_at: -1, exp_sum: 2006, exp_max: 63, exp_err: 1};
    frames[4] = '{skip: -1, dup: -1, stray: 1, rev: 0, toggle: 0, rst_at: -1, exp_sum: 2016, exp_max: 63, exp_err: 1};
    frames[5] = '{skip: -1, dup: -1, stray: 0, rev: 1, toggle: 0, rst_at: -1, exp_sum: 2080, exp_max: 64, exp_err: 0};
    frames[6] = '{skip: -1, dup: -1, stray: 0, rev: 0, toggle: 0, rst_at: 20, exp_sum: 2016, exp_max: 63, exp_err: 0};

    RST = 1'b1; iData = '0; iAddr = '0; iValid = 1'b0; iDone = 1'b0; iDrain = 1'b0; iReady = 1'b0;
    step();
    step();
    RST = 1'b0;
    chk("reset_outputs", {oData, oAddr, oValid, oSum, oMax, oSumValid, oDone, oError}, 0);
    chk("reset_busy", oBusy, 0);

    // iDrain and iDone in IDLE must not start anything
    iDrain = 1'b1; iDone = 1'b1; iReady = 1'b1;
    step();
    iDrain = 1'b0; iDone = 1'b0;
    step();
    step();
    chk("idle_ignore_busy", oBusy, 0);
    chk("idle_ignore_valid", oValid, 0);
    iReady = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(frames[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
